// File: rtl/seg_display_sched.sv
// Round-robin scheduler sharing a 4-digit hex display among four 16-bit requesters.
// The winner's value is snapshotted and held for DWELL cycles, or until next or a dropped request.
module seg_display_sched #(
    parameter int unsigned DWELL = 50_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [15:0] data0,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    input  logic [15:0] data3,
    input  logic        hold,
    input  logic        next,
    output logic [3:0]  grant,
    output logic [1:0]  src,
    output logic [3:0]  in1,
    output logic [3:0]  in2,
    output logic [3:0]  in3,
    output logic [3:0]  in4,
    output logic        busy
);

    typedef enum logic [1:0] {StIdle, StLoad, StShow} state_e;

    localparam logic [31:0] LastCount = 32'(DWELL - 1);

    state_e      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [1:0]  src_q, src_d;
    logic [1:0]  last_q, last_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] disp_q, disp_d;
    logic        busy_q, busy_d;

    logic [15:0] sel_data;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  scan_idx;
    logic        expired;
    logic        rotate;

    always_comb begin
        case (src_q)
            2'd0:    sel_data = data0;
            2'd1:    sel_data = data1;
            2'd2:    sel_data = data2;
            default: sel_data = data3;
        endcase
    end

    // Scan from last+1 upward with wrap; offset 4 lands back on last so a lone owner is re-granted.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last_q;
        scan_idx   = last_q;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_q + 2'(k);
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    assign expired = (cnt_q == LastCount) && !hold;
    assign rotate  = expired || next || !req[src_q];

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        src_d   = src_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        busy_d  = busy_q;
        case (state_q)
            StIdle: begin
                grant_d = 4'b0000;
                busy_d  = 1'b0;
                if (pick_found) begin
                    state_d = StLoad;
                    grant_d = 4'b0001 << pick_idx;
                    src_d   = pick_idx;
                    last_d  = pick_idx;
                    busy_d  = 1'b1;
                end
            end
            StLoad: begin
                disp_d  = sel_data;
                cnt_d   = 32'd0;
                state_d = StShow;
            end
            StShow: begin
                if (!hold) begin
                    cnt_d = cnt_q + 32'd1;
                end
                if (rotate) begin
                    if (pick_found) begin
                        state_d = StLoad;
                        grant_d = 4'b0001 << pick_idx;
                        src_d   = pick_idx;
                        last_d  = pick_idx;
                    end else begin
                        state_d = StIdle;
                        grant_d = 4'b0000;
                        busy_d  = 1'b0;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = 4'b0000;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= 4'b0000;
            src_q   <= 2'd0;
            last_q  <= 2'd3;
            cnt_q   <= 32'd0;
            disp_q  <= 16'h0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            src_q   <= src_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
            busy_q  <= busy_d;
        end
    end

    assign grant = grant_q;
    assign src   = src_q;
    assign busy  = busy_q;
    assign in1   = disp_q[3:0];
    assign in2   = disp_q[7:4];
    assign in3   = disp_q[11:8];
    assign in4   = disp_q[15:12];

endmodule

// File: tb/tb_seg_display_sched.sv
// Directed bench for seg_display_sched with DWELL=4 and hand-computed expectations.
module tb_seg_display_sched;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [15:0] data0, data1, data2, data3;
    logic        hold;
    logic        next;
    logic [3:0]  grant;
    logic [1:0]  src;
    logic [3:0]  in1, in2, in3, in4;
    logic        busy;
    logic [15:0] digits;

    int checks;
    int fails;

    assign digits = {in4, in3, in2, in1};

    seg_display_sched #(.DWELL(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .data0 (data0),
        .data1 (data1),
        .data2 (data2),
        .data3 (data3),
        .hold  (hold),
        .next  (next),
        .grant (grant),
        .src   (src),
        .in1   (in1),
        .in2   (in2),
        .in3   (in3),
        .in4   (in4),
        .busy  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs are driven and outputs sampled 1 time unit after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || src !== 2'd0 || digits !== 16'h0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: grant=%b src=%0d digits=%h busy=%b, want 0000 0 0000 0",
                     grant, src, digits, busy);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        req   = 4'b0001;
        data0 = 16'h1234;
        tick();
        checks++;
        if (grant !== 4'b0001 || src !== 2'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_grant: grant=%b src=%0d busy=%b, want 0001 0 1", grant, src, busy);
        end
        checks++;
        if (digits !== 16'h0000) begin
            fails++;
            $display("FAIL basic_digits_early: digits=%h, want 0000", digits);
        end
        tick();
        checks++;
        if (digits !== 16'h1234 || busy !== 1'b1) begin
            fails++;
            $display("FAIL basic_digits: digits=%h busy=%b, want 1234 1", digits, busy);
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || digits !== 16'h1234) begin
            fails++;
            $display("FAIL basic_release: grant=%b busy=%b digits=%h, want 0000 0 1234",
                     grant, busy, digits);
        end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_g;
        pulse_reset();
        data0 = 16'hAAA0;
        data1 = 16'hAAA1;
        data2 = 16'hAAA2;
        data3 = 16'hAAA3;
        req   = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_g = 4'b0001 << (n % 4);
            tick();
            checks++;
            if (grant !== exp_g || src !== 2'(n % 4) || busy !== 1'b1) begin
                fails++;
                $display("FAIL rot_grant[%0d]: grant=%b src=%0d busy=%b, want %b %0d 1",
                         n, grant, src, busy, exp_g, n % 4);
            end
            tick();
            checks++;
            if (digits !== 16'hAAA0 + 16'(n % 4)) begin
                fails++;
                $display("FAIL rot_digits[%0d]: digits=%h, want %h", n, digits,
                         16'hAAA0 + 16'(n % 4));
            end
            for (int c = 0; c < 3; c++) begin
                tick();
                checks++;
                if (grant !== exp_g) begin
                    fails++;
                    $display("FAIL rot_hold[%0d.%0d]: grant=%b, want %b", n, c, grant, exp_g);
                end
            end
        end
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL rot_idle: grant=%b busy=%b, want 0000 0", grant, busy);
        end
    endtask

    task automatic test_next_hold();
        pulse_reset();
        data0 = 16'h1111;
        data2 = 16'h2222;
        req   = 4'b0101;
        tick();
        tick();
        tick();
        checks++;
        if (grant !== 4'b0001 || digits !== 16'h1111) begin
            fails++;
            $display("FAIL next_start: grant=%b digits=%h, want 0001 1111", grant, digits);
        end
        hold = 1'b1;
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if (grant !== 4'b0100 || src !== 2'd2) begin
            fails++;
            $display("FAIL next_rotate: grant=%b src=%0d, want 0100 2", grant, src);
        end
        tick();
        checks++;
        if (digits !== 16'h2222) begin
            fails++;
            $display("FAIL next_digits: digits=%h, want 2222", digits);
        end
        // Hold well past DWELL: no rotation may happen.
        for (int c = 0; c < 6; c++) tick();
        checks++;
        if (grant !== 4'b0100 || digits !== 16'h2222) begin
            fails++;
            $display("FAIL hold_freeze: grant=%b digits=%h, want 0100 2222", grant, digits);
        end
        next = 1'b1;
        tick();
        next = 1'b0;
        checks++;
        if (grant !== 4'b0001 || src !== 2'd0) begin
            fails++;
            $display("FAIL next_return: grant=%b src=%0d, want 0001 0", grant, src);
        end
        tick();
        checks++;
        if (digits !== 16'h1111) begin
            fails++;
            $display("FAIL next_return_digits: digits=%h, want 1111", digits);
        end
        hold = 1'b0;
        req  = 4'b0000;
        tick();
    endtask

    task automatic test_drop();
        pulse_reset();
        data2 = 16'hCAFE;
        data3 = 16'hBEEF;
        req   = 4'b0100;
        tick();
        checks++;
        if (grant !== 4'b0100) begin
            fails++;
            $display("FAIL drop_grant: grant=%b, want 0100", grant);
        end
        tick();
        tick();
        req = 4'b0000;
        tick();
        checks++;
        if (grant !== 4'b0000 || busy !== 1'b0 || digits !== 16'hCAFE) begin
            fails++;
            $display("FAIL drop_idle: grant=%b busy=%b digits=%h, want 0000 0 cafe",
                     grant, busy, digits);
        end
        tick();
        req = 4'b1000;
        tick();
        checks++;
        if (grant !== 4'b1000 || src !== 2'd3) begin
            fails++;
            $display("FAIL drop_regrant: grant=%b src=%0d, want 1000 3", grant, src);
        end
        tick();
        checks++;
        if (digits !== 16'hBEEF) begin
            fails++;
            $display("FAIL drop_regrant_digits: digits=%h, want beef", digits);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_refresh();
        pulse_reset();
        data1 = 16'h0001;
        req   = 4'b0010;
        tick();
        tick();
        tick();
        data1 = 16'h0002;
        tick();
        tick();
        checks++;
        if (digits !== 16'h0001 || grant !== 4'b0010) begin
            fails++;
            $display("FAIL refresh_frozen: digits=%h grant=%b, want 0001 0010", digits, grant);
        end
        tick();
        checks++;
        if (digits !== 16'h0001 || grant !== 4'b0010 || busy !== 1'b1) begin
            fails++;
            $display("FAIL refresh_regrant: digits=%h grant=%b busy=%b, want 0001 0010 1",
                     digits, grant, busy);
        end
        tick();
        checks++;
        if (digits !== 16'h0002) begin
            fails++;
            $display("FAIL refresh_digits: digits=%h, want 0002", digits);
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 4'b0000 || src !== 2'd0 || digits !== 16'h0000 || busy !== 1'b0) begin
            fails++;
            $display("FAIL async_reset: grant=%b src=%0d digits=%h busy=%b, want 0000 0 0000 0",
                     grant, src, digits, busy);
        end
        rst = 1'b0;
        req = 4'b1111;
        tick();
        checks++;
        if (grant !== 4'b0001 || src !== 2'd0) begin
            fails++;
            $display("FAIL async_first_grant: grant=%b src=%0d, want 0001 0", grant, src);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        rst    = 1'b0;
        req    = 4'b0000;
        data0  = 16'h0000;
        data1  = 16'h0000;
        data2  = 16'h0000;
        data3  = 16'h0000;
        hold   = 1'b0;
        next   = 1'b0;
        #1;
        test_reset();
        test_basic();
        test_rotation();
        test_next_hold();
        test_drop();
        test_refresh();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
